// File: rtl/register_file_mp_pkg.sv
// Shared types and the byte-merge helper used by the write path and the read-port bypass.
package register_file_pkg;

   typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

   // Widest word the shared merge helper supports; callers size-cast in and out.
   localparam int unsigned RF_MAX_DATA_WIDTH = 256;
   localparam int unsigned RF_MAX_BE_WIDTH   = RF_MAX_DATA_WIDTH / 8;

   function automatic logic [RF_MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [RF_MAX_DATA_WIDTH-1:0] oldWord,
      input logic [RF_MAX_DATA_WIDTH-1:0] newWord,
      input logic [RF_MAX_BE_WIDTH-1:0]   be
   );
      logic [RF_MAX_DATA_WIDTH-1:0] merged;
      merged = oldWord;
      for (int unsigned i = 0; i < RF_MAX_BE_WIDTH; i++) begin
         if (be[i]) merged[i*8 +: 8] = newWord[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Write, read and clear/ready signals of the multi-port register file.
interface register_file_mp_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 6,
   parameter int NUM_READ_PORTS = 2
);
   logic                                        ClearRequest;
   logic                                        Ready;
   logic                                        WriteEnable;
   logic [ADDR_WIDTH-1:0]                       WriteAddress;
   logic [DATA_WIDTH-1:0]                       WriteData;
   logic [DATA_WIDTH/8-1:0]                     WriteByteEnable;
   logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]   ReadAddress;
   logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]   ReadData;

   modport master (
      output ClearRequest, WriteEnable, WriteAddress, WriteData, WriteByteEnable, ReadAddress,
      input  Ready, ReadData
   );

   modport slave (
      input  ClearRequest, WriteEnable, WriteAddress, WriteData, WriteByteEnable, ReadAddress,
      output Ready, ReadData
   );
endinterface

// File: rtl/register_file_mp_read_port.sv
// One asynchronous read port: applies write bypass, the zero register and clear-time forcing.
module rf_read_port
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 0
) (
   input  logic [DATA_WIDTH-1:0]   ArrayWord,
   input  logic                    Ready,
   input  logic                    WriteEnable,
   input  logic [ADDR_WIDTH-1:0]   WriteAddress,
   input  logic [DATA_WIDTH-1:0]   WriteData,
   input  logic [DATA_WIDTH/8-1:0] WriteByteEnable,
   input  logic [ADDR_WIDTH-1:0]   ReadAddress,
   output logic [DATA_WIDTH-1:0]   ReadData
);

   always_comb begin
      ReadData = ArrayWord;
      if ((BYPASS != 0) && Ready && WriteEnable && (ReadAddress == WriteAddress)) begin
         ReadData = DATA_WIDTH'(byte_merge(RF_MAX_DATA_WIDTH'(ArrayWord),
                                           RF_MAX_DATA_WIDTH'(WriteData),
                                           RF_MAX_BE_WIDTH'(WriteByteEnable)));
      end
      // Zero register and clear sweep override everything, bypass included.
      if (!Ready || ((ZERO_REG != 0) && (ReadAddress == '0))) ReadData = '0;
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enabled write and a sequential clear sweep.
module register_file_mp
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 6,
   parameter int NUM_READ_PORTS = 2,
   parameter int BYPASS         = 1,
   parameter int ZERO_REG       = 0
) (
   input logic               Clock,
   input logic               Reset,
   register_file_mp_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > RF_MAX_DATA_WIDTH) begin : gBadWidth
      $error("register_file_mp: DATA_WIDTH must be a multiple of 8 and at most %0d", RF_MAX_DATA_WIDTH);
   end
   if (NUM_READ_PORTS < 1) begin : gBadPorts
      $error("register_file_mp: NUM_READ_PORTS must be at least 1");
   end

   rf_state_t             state, nextState;
   logic [ADDR_WIDTH-1:0] clearPtr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] writeMerged;
   logic                  writeAccept;

   always_ff @(posedge Clock) begin
      if (Reset) state <= RF_CLEAR;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         RF_CLEAR: if (clearPtr == '1) nextState = RF_READY;
         RF_READY: if (bus.ClearRequest) nextState = RF_CLEAR;
      endcase
   end

   always_comb bus.Ready = (state == RF_READY);

   // Pointer idles at 0 in READY, so a clear request always starts the sweep at entry 0.
   always_ff @(posedge Clock) begin
      if (Reset)                  clearPtr <= '0;
      else if (state == RF_CLEAR) clearPtr <= clearPtr + 1'b1;
      else                        clearPtr <= '0;
   end

   always_comb begin
      writeAccept = (state == RF_READY) && bus.WriteEnable && !bus.ClearRequest &&
                    !((ZERO_REG != 0) && (bus.WriteAddress == '0));
      writeMerged = DATA_WIDTH'(byte_merge(RF_MAX_DATA_WIDTH'(mem[bus.WriteAddress]),
                                           RF_MAX_DATA_WIDTH'(bus.WriteData),
                                           RF_MAX_BE_WIDTH'(bus.WriteByteEnable)));
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         if (state == RF_CLEAR) mem[clearPtr] <= '0;
         else if (writeAccept)  mem[bus.WriteAddress] <= writeMerged;
      end
   end

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gReadPort
      rf_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .BYPASS     (BYPASS),
         .ZERO_REG   (ZERO_REG)
      ) uReadPort (
         .ArrayWord       (mem[bus.ReadAddress[p]]),
         .Ready           (bus.Ready),
         .WriteEnable     (bus.WriteEnable),
         .WriteAddress    (bus.WriteAddress),
         .WriteData       (bus.WriteData),
         .WriteByteEnable (bus.WriteByteEnable),
         .ReadAddress     (bus.ReadAddress[p]),
         .ReadData        (bus.ReadData[p])
      );
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: default build, BYPASS=0 build and ZERO_REG=1 build.
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst      [3];
  logic                  clearReq [3];
  logic                  we       [3];
  logic [5:0]            wa       [3];
  logic [15:0]           wd       [3];
  logic [1:0]            be       [3];
  logic [1:0][5:0]       ra       [3];
  logic [1:0][15:0]      rdat     [3];
  logic                  rdy      [3];

  register_file_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .NUM_READ_PORTS(2)) bus [3] ();

  for (genvar d = 0; d < 3; d++) begin : gDut
    assign bus[d].ClearRequest    = clearReq[d];
    assign bus[d].WriteEnable     = we[d];
    assign bus[d].WriteAddress    = wa[d];
    assign bus[d].WriteData       = wd[d];
    assign bus[d].WriteByteEnable = be[d];
    assign bus[d].ReadAddress     = ra[d];
    assign rdat[d]                = bus[d].ReadData;
    assign rdy[d]                 = bus[d].Ready;

    register_file_mp #(
      .DATA_WIDTH     (16),
      .ADDR_WIDTH     (6),
      .NUM_READ_PORTS (2),
      .BYPASS         ((d == 1) ? 0 : 1),
      .ZERO_REG       ((d == 2) ? 1 : 0)
    ) uDut (
      .Clock (clk),
      .Reset (rst[d]),
      .bus   (bus[d])
    );
  end

  typedef struct {
    int          dut;
    int          port;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int compared   = 0;
  int mismatched = 0;
  logic done = 1'b0;

  always @(negedge clk) begin
    chk_t        e;
    logic [15:0] act;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = (e.port < 0) ? {15'b0, rdy[e.dut]} : rdat[e.dut][e.port];
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s (dut%0d port%0d): got %h, want %h", e.name, e.dut, e.port, act, e.exp);
      end
    end
  end

  initial begin
    repeat (2000) @(posedge clk);
    if (!done) begin
      mismatched++;
      $display("FAIL timeout: sequence did not complete within 2000 cycles");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  task automatic checkNow(logic [15:0] act, logic [15:0] exp, string n);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expRd(int d, int p, logic [5:0] a, logic [15:0] v, string n);
    chk_t e;
    ra[d][p] = a;
    e.dut = d; e.port = p; e.exp = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic expRdy(int d, logic v, string n);
    chk_t e;
    e.dut = d; e.port = -1; e.exp = {15'b0, v}; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic wr(int d, logic [5:0] a, logic [15:0] v, logic [1:0] b);
    we[d] = 1'b1; wa[d] = a; wd[d] = v; be[d] = b;
  endtask

  task automatic idle(int d);
    we[d] = 1'b0;
  endtask

  initial begin
    for (int unsigned d = 0; d < 3; d++) begin
      rst[d] = 1'b1; clearReq[d] = 1'b0; we[d] = 1'b0;
      wa[d] = '0; wd[d] = '0; be[d] = '0; ra[d] = '0;
    end

    tick();
    for (int unsigned d = 0; d < 3; d++) begin
      checkNow({15'b0, rdy[d]}, 16'h0000, "resetReady");
      checkNow(rdat[d][0], 16'h0000, "resetRead0");
      checkNow(rdat[d][1], 16'h0000, "resetRead1");
    end
    tick();
    for (int unsigned d = 0; d < 3; d++) begin
      checkNow({15'b0, rdy[d]}, 16'h0000, "resetReadyHeld");
      rst[d] = 1'b0;
      expRdy(d, 1'b0, "readyAfterReset");
    end
    for (int unsigned k = 1; k <= 63; k++) begin
      tick();
      for (int unsigned d = 0; d < 3; d++) begin
        expRdy(d, 1'b0, "sweepReady");
        expRd(d, 0, 6'(k), 16'h0000, "sweepRead0");
        expRd(d, 1, 6'(63 - k), 16'h0000, "sweepRead1");
      end
    end
    tick();
    for (int unsigned d = 0; d < 3; d++) begin
      expRdy(d, 1'b1, "readyRiseEdge64");
      expRd(d, 0, 6'h3F, 16'h0000, "clearedTop");
      expRd(d, 1, 6'h00, 16'h0000, "clearedBottom");
    end

    tick();
    wr(0, 6'h0B, 16'h1FF4, 2'b11);
    tick();
    idle(0); wd[0] = 16'h0040;
    expRd(0, 0, 6'h0B, 16'h1FF4, "writeP0");
    expRd(0, 1, 6'h0B, 16'h1FF4, "writeP1");
    tick();
    expRd(0, 0, 6'h0B, 16'h1FF4, "weLowP0");
    expRd(0, 1, 6'h0B, 16'h1FF4, "weLowP1");

    tick();
    wr(0, 6'h09, 16'h1234, 2'b11);
    tick();
    wr(0, 6'h09, 16'hABCD, 2'b10);
    expRd(0, 0, 6'h09, 16'hAB34, "bypassMerge");
    expRd(0, 1, 6'h0B, 16'h1FF4, "otherPortIndep");
    tick();
    wr(0, 6'h09, 16'hFFFF, 2'b00);
    expRd(0, 0, 6'h09, 16'hAB34, "beZeroBypass");
    tick();
    idle(0);
    expRd(0, 0, 6'h09, 16'hAB34, "beMergeStored");
    expRd(0, 1, 6'h09, 16'hAB34, "beZeroNoop");

    tick();
    wr(1, 6'h3B, 16'h5555, 2'b11);
    expRd(1, 0, 6'h3B, 16'h0000, "noBypassOldP0");
    expRd(1, 1, 6'h3B, 16'h0000, "noBypassOldP1");
    tick();
    idle(1);
    expRd(1, 0, 6'h3B, 16'h5555, "noBypassNewP0");
    expRd(1, 1, 6'h3B, 16'h5555, "noBypassNewP1");

    tick();
    wr(2, 6'h01, 16'h1111, 2'b11);
    tick();
    wr(2, 6'h00, 16'h7777, 2'b11);
    expRd(2, 0, 6'h00, 16'h0000, "zeroRegBypass");
    expRd(2, 1, 6'h01, 16'h1111, "zeroRegAddr1");
    tick();
    idle(2);
    expRd(2, 0, 6'h00, 16'h0000, "zeroRegAfter");
    expRd(2, 1, 6'h01, 16'h1111, "zeroRegAddr1After");

    tick();
    clearReq[0] = 1'b1;
    wr(0, 6'h01, 16'hFFFF, 2'b11);
    expRdy(0, 1'b1, "readyBeforeClear");
    tick();
    clearReq[0] = 1'b0;
    idle(0);
    expRdy(0, 1'b0, "clearFall");
    expRd(0, 0, 6'h0B, 16'h0000, "clearForcedRead");
    for (int unsigned k = 1; k <= 29; k++) begin
      tick();
      expRdy(0, 1'b0, "clearSweepReady");
    end
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    expRdy(0, 1'b0, "resetMidSweep");
    for (int unsigned k = 1; k <= 63; k++) begin
      tick();
      if (k == 60) wr(0, 6'h05, 16'hBEEF, 2'b11);
      if (k == 61) idle(0);
      expRdy(0, 1'b0, "restartSweepReady");
    end
    tick();
    expRdy(0, 1'b1, "restartReadyRise");
    expRd(0, 0, 6'h01, 16'h0000, "clearDroppedWrite");
    expRd(0, 1, 6'h05, 16'h0000, "writeIgnoredInClear");
    tick();
    expRd(0, 0, 6'h0B, 16'h0000, "clearedEntry0B");
    expRd(0, 1, 6'h09, 16'h0000, "clearedEntry09");

    @(negedge clk);
    #1;
    done = 1'b1;
    if (mismatched == 0 && compared > 0) $display("PASS");
    else                                 $display("FAIL");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
